// File: rtl/bin_to_bcd_seq_if.sv
// ============================================================================
// Module   : bin_to_bcd_seq_if
// Purpose  : valid/ready bus of the sequential binary-to-BCD converter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bin_to_bcd_seq_if #(
    parameter int W  = 8,
    parameter int ND = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    bin;
    logic            out_valid;
    logic            out_ready;
    logic [4*ND-1:0] dec;
    logic            ovf;
    logic            busy;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, dec, ovf, busy
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, dec, ovf, busy
    );
endinterface

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : double-dabble binary-to-BCD converter, one shift per clock
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq #(
    parameter int W  = 8,
    parameter int ND = 3
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          cl,
    bin_to_bcd_seq_if.slave    bus
);
    localparam int CW = $clog2(W + 1);
    localparam int AW = 4 * ND;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    b_q, b_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   adj;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    // Per-digit add-3 correction; digits are independent, no carry between them
    generate
        for (genvar k = 0; k < ND; k++) begin : g_digit
            assign adj[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ? (acc_q[4*k +: 4] + 4'd3)
                                                              : acc_q[4*k +: 4];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    b_d     = bus.bin;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {acc_d, b_d} = {adj, b_q} << 1;
                ovf_d        = ovf_q | adj[AW-1];
                cnt_d        = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear overrides every transition, including an accept in the same cycle
        if (cl) begin
            state_d = S_IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_SHIFT);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.dec       = acc_q;
    assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Purpose  : scoreboard bench for bin_to_bcd_seq (ND=3 and ND=2 instances)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst_n;
    logic cl;
    int   checks = 0;
    int   errors = 0;
    longint t_acc, t_prev;

    logic [12:0] q1[$];
    logic [8:0]  q2[$];

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.W(8), .ND(3)) b1 ();
    bin_to_bcd_seq_if #(.W(8), .ND(2)) b2 ();

    bin_to_bcd_seq #(.W(8), .ND(3)) u_dut3 (
        .clk     (clk),
        .reset_n (rst_n),
        .cl      (cl),
        .bus     (b1.slave)
    );

    bin_to_bcd_seq #(.W(8), .ND(2)) u_dut2 (
        .clk     (clk),
        .reset_n (rst_n),
        .cl      (cl),
        .bus     (b2.slave)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [11:0] bcd3(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Scoreboard monitors: pop on every completed output handshake
    always @(negedge clk) begin
        if (rst_n && b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) begin
                check("dut3_unexpected_out", 32'd1, 32'd0);
            end else begin
                logic [12:0] e;
                e = q1.pop_front();
                check("dut3_result", {19'd0, b1.dec, b1.ovf}, {19'd0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b2.out_valid && b2.out_ready) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_out", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = q2.pop_front();
                check("dut2_result", {23'd0, b2.dec, b2.ovf}, {23'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [7:0] v, input bit exp_out, input logic [11:0] d, input bit o);
        int n;
        n = 0;
        while (!b1.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("dut3_in_ready_timeout", 32'd0, 32'd1);
        b1.in_valid = 1'b1;
        b1.bin      = v;
        if (exp_out) q1.push_back({d, o});
        tick();
        t_acc       = $time - 1;
        b1.in_valid = 1'b0;
        b1.bin      = ~v;
    endtask

    task automatic send2(input logic [7:0] v, input logic [7:0] d, input bit o);
        int n;
        n = 0;
        while (!b2.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("dut2_in_ready_timeout", 32'd0, 32'd1);
        b2.in_valid = 1'b1;
        b2.bin      = v;
        q2.push_back({d, o});
        tick();
        b2.in_valid = 1'b0;
        b2.bin      = ~v;
    endtask

    // Latency counted inclusively from the accepting edge
    task automatic timed1(input logic [7:0] v, input logic [11:0] d);
        int lat, bcnt;
        send1(v, 1'b1, d, 1'b0);
        lat  = 1;
        bcnt = 0;
        while (!b1.out_valid && lat < 50) begin
            if (b1.busy) bcnt++;
            tick();
            lat++;
        end
        check("latency_edges", 32'(lat), 32'd9);
        check("busy_cycles", 32'(bcnt), 32'd8);
    endtask

    initial begin
        int  n;
        bit  seen;

        rst_n = 1'b0;
        cl    = 1'b0;
        b1.in_valid = 1'b0; b1.bin = '0; b1.out_ready = 1'b0;
        b2.in_valid = 1'b0; b2.bin = '0; b2.out_ready = 1'b1;
        #3;
        check("reset_state", {b1.in_ready, b1.out_valid, b1.busy, b1.ovf, 16'd0, b1.dec},
                             {1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 12'h000});
        #9 rst_n = 1'b1;
        tick();

        send2(8'd200, 8'h00, 1'b1);
        send2(8'd99,  8'h99, 1'b0);
        send2(8'd100, 8'h00, 1'b1);

        b1.out_ready = 1'b1;
        timed1(8'd0,   12'h000);
        timed1(8'd255, 12'h255);

        // Clear and valid together in IDLE: no accept
        send1(8'd1, 1'b1, 12'h001, 1'b0);
        while (!b1.in_ready) tick();
        cl = 1'b1; b1.in_valid = 1'b1; b1.bin = 8'd55;
        tick();
        cl = 1'b0; b1.in_valid = 1'b0;
        check("cl_vs_in_valid", {b1.in_ready, b1.busy}, {1'b1, 1'b0});

        // Back-pressure
        b1.out_ready = 1'b0;
        send1(8'd137, 1'b1, 12'h137, 1'b0);
        n = 0;
        while (!b1.out_valid && n < 30) begin tick(); n++; end
        if (n >= 30) check("bp_out_valid_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 20; i++) begin
            check("bp_hold", {b1.out_valid, b1.in_ready, b1.ovf, b1.dec},
                             {1'b1, 1'b0, 1'b0, 12'h137});
            tick();
        end
        b1.out_ready = 1'b1;
        tick();
        check("bp_release", {b1.in_ready, b1.out_valid}, {1'b1, 1'b0});

        // Abort in the 4th SHIFT cycle
        send1(8'd255, 1'b0, 12'h000, 1'b0);
        tick(); tick(); tick();
        cl = 1'b1;
        tick();
        cl = 1'b0;
        check("abort_state", {b1.in_ready, b1.busy, b1.out_valid, b1.ovf, b1.dec},
                             {1'b1, 1'b0, 1'b0, 1'b0, 12'h000});
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (b1.out_valid) seen = 1'b1;
            tick();
        end
        check("abort_no_out", {31'd0, seen}, 32'd0);
        send1(8'd42, 1'b1, 12'h042, 1'b0);

        // Asynchronous reset between edges during SHIFT
        while (!b1.in_ready) tick();
        send1(8'd99, 1'b0, 12'h000, 1'b0);
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("async_reset", {b1.in_ready, b1.out_valid, b1.busy, b1.ovf, b1.dec},
                             {1'b1, 1'b0, 1'b0, 1'b0, 12'h000});
        #1 rst_n = 1'b1;
        tick();
        send1(8'd7, 1'b1, 12'h007, 1'b0);

        // Back-to-back sweep of every input
        while (!b1.in_ready) tick();
        for (int v = 0; v < 256; v++) begin
            t_prev = t_acc;
            send1(8'(v), 1'b1, bcd3(v), 1'b0);
            if (v > 0) check("sweep_period", 32'(t_acc - t_prev), 32'd100);
        end

        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin tick(); n++; end
        check("drain_timeout", 32'(q1.size() + q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
